// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the 8N1 UART.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Clocks per serial bit, floored at 1 so slow clocks still elaborate.
    function automatic int unsigned calc_tx_div(input int unsigned clk_freq,
                                                input int unsigned baud);
        int unsigned d;
        d = clk_freq / baud;
        return (d < 1) ? 1 : d;
    endfunction

    // Clocks per RX oversampling tick, floored at 1.
    function automatic int unsigned calc_rx_div(input int unsigned clk_freq,
                                                input int unsigned baud,
                                                input int unsigned oversample);
        int unsigned d;
        d = clk_freq / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_modport_if.sv
// Host-side and pin-side signals of the UART, split into TX and RX views.
interface uart_modport_if;
    import uart_pkg::*;

    logic                 wr_en;
    logic [DATA_BITS-1:0] din;
    logic                 tx;
    logic                 tx_busy;
    logic                 rx;
    logic                 rdy_clr;
    logic                 rdy;
    logic [DATA_BITS-1:0] dout;

    modport uart_tx (input wr_en, input din, output tx, output tx_busy);
    modport uart_rx (input rx, input rdy_clr, output rdy, output dout);
    modport host    (output wr_en, output din, output rdy_clr,
                     input tx, input tx_busy, input rdy, input dout);

endinterface

// File: rtl/uart_rx_core.sv
// Oversampling 8N1 receiver with mid-bit sampling and a rdy/rdy_clr handshake.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned RX_DIV     = 27,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_modport_if.uart_rx bus
);

    localparam int unsigned TICK_W = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam int unsigned SMP_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned IDX_W  = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(RX_DIV - 1);
    localparam logic [SMP_W-1:0]  SMP_MID   = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0]  SMP_LAST  = SMP_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic                 rx_meta_q, rx_sync_q;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [SMP_W-1:0]     smp_q, smp_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 rdy_q, rdy_d;
    logic                 ferr_q, ferr_d;
    logic                 tick;

    assign tick = (tick_cnt_q == TICK_LAST);

    // Two-flop synchronizer; idles high like the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RX_IDLE;
            tick_cnt_q <= '0;
            smp_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            rdy_q      <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            smp_q      <= smp_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            rdy_q      <= rdy_d;
            ferr_q     <= ferr_d;
        end
    end

    // rdy_clr is applied first so a byte completing on the same edge wins.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        smp_d      = smp_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        rdy_d      = bus.rdy_clr ? 1'b0 : rdy_q;
        ferr_d     = ferr_q;
        case (state_q)
            RX_IDLE: begin
                if (!rx_sync_q) begin
                    smp_d      = '0;
                    tick_cnt_d = '0;
                    ferr_d     = 1'b0;
                    state_d    = RX_START;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (smp_q == SMP_MID) begin
                        smp_d   = '0;
                        idx_d   = '0;
                        state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (smp_q == SMP_LAST) begin
                        smp_d   = '0;
                        shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
                        if (idx_q == IDX_LAST) state_d = RX_STOP;
                        else                   idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            RX_STOP: begin
                if (ferr_q) begin
                    // Framing error: park until the line returns to idle.
                    if (rx_sync_q) begin
                        ferr_d  = 1'b0;
                        state_d = RX_IDLE;
                    end
                end else if (tick) begin
                    if (smp_q == SMP_LAST) begin
                        if (rx_sync_q) begin
                            dout_d  = shift_q;
                            rdy_d   = 1'b1;
                            state_d = RX_IDLE;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        smp_d = smp_q + SMP_W'(1);
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign bus.rdy  = rdy_q;
    assign bus.dout = dout_q;

endmodule

// File: rtl/uart_tx_core.sv
// 8N1 transmitter: latches a byte on wr_en and shifts it out LSB first.
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int unsigned TX_DIV = 434
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_modport_if.uart_tx bus
);

    localparam int unsigned CNT_W = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // tx is registered, so each state presets the level of the next bit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (bus.wr_en) begin
                    shift_d = bus.din;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = TX_START;
                end
            end
            TX_START: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        tx_d    = 1'b1;
                        state_d = TX_STOP;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            TX_STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
                if (bit_end) begin
                    busy_d  = 1'b0;
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;

endmodule

// File: rtl/uart_modport.sv
// Full-duplex 8N1 UART top: independent TX and RX cores on one clock.
module uart_modport
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic           clk_50m,
    input  logic           rst_n,
    uart_modport_if.uart_tx tx_if,
    uart_modport_if.uart_rx rx_if
);

    localparam int unsigned TX_DIV = calc_tx_div(CLK_FREQ, BAUD);
    localparam int unsigned RX_DIV = calc_rx_div(CLK_FREQ, BAUD, OVERSAMPLE);

    uart_tx_core #(
        .TX_DIV (TX_DIV)
    ) u_tx (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .bus   (tx_if)
    );

    uart_rx_core #(
        .RX_DIV     (RX_DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk   (clk_50m),
        .rst_n (rst_n),
        .bus   (rx_if)
    );

endmodule

// File: tb/tb_uart_modport.sv
// Directed + random bench for uart_modport with 16 clocks per serial bit.
module tb_uart_modport;

    localparam int unsigned BIT_CLKS = 16;

    logic clk;
    logic rst_n;
    logic loopback;
    logic rx_drv;
    int   total;
    int   bad;

    uart_modport_if uif ();

    assign uif.rx = loopback ? uif.tx : rx_drv;

    uart_modport #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk_50m (clk),
        .rst_n   (rst_n),
        .tx_if   (uif),
        .rx_if   (uif)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Sends b and checks the line against the ideal 8N1 frame at every bit centre.
    task automatic send_check(input logic [7:0] b, input bit poke, input string tag);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        @(negedge clk); uif.wr_en = 1'b1; uif.din = b;
        @(negedge clk); uif.wr_en = 1'b0;
        for (int j = 0; j <= 10 * BIT_CLKS; j++) begin
            if (j > 0) @(negedge clk);
            if (poke && j == 3) begin uif.wr_en = 1'b1; uif.din = 8'h3C; end
            if (poke && j == 4) uif.wr_en = 1'b0;
            if (j == 0) chk({tag, "_busy_on"}, 32'(uif.tx_busy), 32'd1);
            if (j % BIT_CLKS == BIT_CLKS / 2)
                chk($sformatf("%s_bit%0d", tag, j / BIT_CLKS), 32'(uif.tx), 32'(frame[j / BIT_CLKS]));
            if (j == 10 * BIT_CLKS - 1) chk({tag, "_busy_last"}, 32'(uif.tx_busy), 32'd1);
            if (j == 10 * BIT_CLKS) begin
                chk({tag, "_busy_off"}, 32'(uif.tx_busy), 32'd0);
                chk({tag, "_tx_idle"}, 32'(uif.tx), 32'd1);
            end
        end
        @(negedge clk);
        chk({tag, "_stay_idle"}, 32'(uif.tx_busy), 32'd0);
    endtask

    task automatic tx_launch(input logic [7:0] b);
        @(negedge clk); uif.wr_en = 1'b1; uif.din = b;
        @(negedge clk); uif.wr_en = 1'b0;
    endtask

    // Bit-bangs a frame on rx with a chosen stop-bit level.
    task automatic drive_frame(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = frame[k];
            repeat (BIT_CLKS) @(negedge clk);
        end
    endtask

    task automatic wait_rdy(input logic [7:0] exp, input string tag);
        int n;
        n = 0;
        while (uif.rdy !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, 32'(uif.rdy), 32'd1);
        chk({tag, "_dout"}, 32'(uif.dout), 32'(exp));
    endtask

    task automatic clear_rdy(input string tag);
        @(negedge clk); uif.rdy_clr = 1'b1;
        @(negedge clk); uif.rdy_clr = 1'b0;
        chk({tag, "_clr"}, 32'(uif.rdy), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] b2;
        logic [7:0] last_good;
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        loopback = 1'b1;
        rx_drv = 1'b1;
        uif.wr_en = 1'b0;
        uif.din = 8'h00;
        uif.rdy_clr = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(uif.tx), 32'd1);
        chk("rst_busy", 32'(uif.tx_busy), 32'd0);
        chk("rst_rdy", 32'(uif.rdy), 32'd0);
        chk("rst_dout", 32'(uif.dout), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Frame A5 with an ignored request for 3C mid-frame.
        send_check(8'hA5, 1'b1, "a5");
        wait_rdy(8'hA5, "a5_rx");
        clear_rdy("a5");

        // Random loopback bytes, ending with 5A.
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_check(b, 1'b0, $sformatf("rnd%0d", i));
            wait_rdy(b, $sformatf("rnd%0d_rx", i));
            clear_rdy($sformatf("rnd%0d", i));
        end
        send_check(8'h5A, 1'b0, "5a");
        wait_rdy(8'h5A, "5a_rx");
        clear_rdy("5a");
        last_good = 8'h5A;

        // Short low pulse must not be taken as a start bit.
        loopback = 1'b0;
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        chk("glitch_rdy", 32'(uif.rdy), 32'd0);
        chk("glitch_dout", 32'(uif.dout), 32'(last_good));

        // Stop bit low: byte dropped, receiver waits for idle line.
        b = 8'($urandom);
        drive_frame(b, 1'b0);
        repeat (30) @(negedge clk);
        chk("ferr_rdy", 32'(uif.rdy), 32'd0);
        chk("ferr_dout", 32'(uif.dout), 32'(last_good));
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        chk("ferr_rdy_after", 32'(uif.rdy), 32'd0);
        b = 8'($urandom);
        drive_frame(b, 1'b1);
        wait_rdy(b, "recover");
        last_good = b;

        // Overrun: second byte overwrites while rdy stays high.
        loopback = 1'b1;
        b = 8'($urandom);
        b2 = ~b;
        send_check(b, 1'b0, "ovr1");
        wait_rdy(b, "ovr1_rx");
        send_check(b2, 1'b0, "ovr2");
        chk("ovr_rdy", 32'(uif.rdy), 32'd1);
        chk("ovr_dout", 32'(uif.dout), 32'(b2));

        // rdy_clr held across completion: the new byte still raises rdy.
        b = 8'($urandom);
        uif.rdy_clr = 1'b1;
        tx_launch(b);
        chk("hold_clr_low", 32'(uif.rdy), 32'd0);
        wait_rdy(b, "hold_clr");
        @(negedge clk);
        chk("hold_clr_after", 32'(uif.rdy), 32'd0);
        uif.rdy_clr = 1'b0;

        // Asynchronous reset in the middle of a TX frame.
        tx_launch(8'($urandom));
        repeat (40) @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(uif.tx), 32'd1);
        chk("arst_busy", 32'(uif.tx_busy), 32'd0);
        chk("arst_rdy", 32'(uif.rdy), 32'd0);
        chk("arst_dout", 32'(uif.dout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        b = 8'($urandom);
        send_check(b, 1'b0, "post_rst");
        wait_rdy(b, "post_rst_rx");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
